// File: rtl/display_pkg.sv
// display_pkg: shared state and select encodings for the display arbiter.
package display_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, SHOW_A = 2'b01, SHOW_B = 2'b10} state_t;
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;
endpackage

// File: rtl/hold_timer.sv
// hold_timer: saturating minimum-hold counter; expired once it reaches HOLD_CYCLES-1.
module hold_timer #(
  parameter int HOLD_CYCLES = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(HOLD_CYCLES);
  localparam logic [W-1:0] MAX = W'(HOLD_CYCLES - 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign expired = cnt_q == MAX;
  always_comb cnt_d = clear ? '0 : (enable && !expired) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
endmodule

// File: rtl/display_arbiter.sv
// display_arbiter: round-robin owner of the shared display with minimum hold time and lock.
module display_arbiter
  import display_pkg::*;
#(
  parameter int HOLD_CYCLES = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic req_a,
  input  logic req_b,
  input  logic lock,
  output logic sel,
  output logic blank,
  output logic grant_a,
  output logic grant_b,
  output logic switch_pulse
);
  state_t state_q, state_d;
  logic sel_q, sel_d, pulse_q, pulse_d, expired, own, other;
  always_comb begin
    state_d = state_q;
    own = state_q == SHOW_A ? req_a : req_b;
    other = state_q == SHOW_A ? req_b : req_a;
    if (!lock) begin
      if (state_q == IDLE)
        state_d = req_a ? SHOW_A : req_b ? SHOW_B : IDLE;
      else if (!own || (expired && other))
        state_d = !other ? IDLE : state_q == SHOW_A ? SHOW_B : SHOW_A;
    end
    sel_d = state_d == SHOW_A ? SEL_A : state_d == SHOW_B ? SEL_B : sel_q;
    pulse_d = state_d != state_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q <= SEL_A;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      pulse_q <= pulse_d;
    end
  end
  // every state change restarts the hold window, so entry always begins at zero
  hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
    .clk(clk),
    .reset(reset),
    .clear(pulse_d),
    .enable(!lock && state_q != IDLE),
    .expired(expired)
  );
  assign grant_a = state_q == SHOW_A;
  assign grant_b = state_q == SHOW_B;
  assign blank = !grant_a && !grant_b;
  assign sel = sel_q;
  assign switch_pulse = pulse_q;
endmodule
